// File: rtl/dphy_rx_lane_ctrl_pkg.sv
// dphy_rx_ctrl_pkg: controller state encoding, LP line codes {Dp,Dn} and a max helper
package dphy_rx_ctrl_pkg;
  typedef enum logic [2:0] {
    DISABLED  = 3'd0,
    STOP      = 3'd1,
    HS_RQST   = 3'd2,
    HS_SETTLE = 3'd3,
    HS_SYNC   = 3'd4,
    HS_DATA   = 3'd5,
    WAIT_STOP = 3'd6
  } rx_ctrl_state_t;
  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP11 = 2'b11;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/dphy_rx_lane_ctrl_if.sv
// dphy_rx_lane_ctrl_if: controller <-> DPHY_HSRX link; master = controller (drives HSRX_EN/HS_TermEn), slave = deserializer (drives RxActiveHS/RxSyncHS/RxValidHS)
interface dphy_rx_lane_ctrl_if;
  logic RxActiveHS;
  logic RxSyncHS;
  logic RxValidHS;
  logic HSRX_EN;
  logic HS_TermEn;
  modport master (input RxActiveHS, RxSyncHS, RxValidHS, output HSRX_EN, HS_TermEn);
  modport slave (output RxActiveHS, RxSyncHS, RxValidHS, input HSRX_EN, HS_TermEn);
endinterface

// File: rtl/dphy_rx_lane_ctrl_lp_sync_filter.sv
// dphy_lp_sync_filter: 2-flop synchronizer on {lp_dp_i,lp_dn_i} plus a LP_FILTER-sample stability filter driving lp (resets to LP-00)
module dphy_lp_sync_filter
  import dphy_rx_ctrl_pkg::*;
#(
  parameter int LP_FILTER = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       lp_dp_i,
  input  logic       lp_dn_i,
  output logic [1:0] lp
);
  localparam int FW = $clog2(LP_FILTER + 1);
  logic [1:0] s1_q, s2_q, cand_q, lp_q;
  logic [FW-1:0] cnt_q, cnt_d;
  assign cnt_d = (s2_q != cand_q) ? FW'(1) : (cnt_q == FW'(LP_FILTER)) ? cnt_q : cnt_q + FW'(1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= LP00;
      s2_q   <= LP00;
      cand_q <= LP00;
      cnt_q  <= '0;
      lp_q   <= LP00;
    end else begin
      s1_q   <= {lp_dp_i, lp_dn_i};
      s2_q   <= s1_q;
      cand_q <= s2_q;
      cnt_q  <= cnt_d;
      if (cnt_d >= FW'(LP_FILTER)) lp_q <= s2_q;
    end
  end
  assign lp = lp_q;
endmodule

// File: rtl/dphy_rx_lane_ctrl.sv
// dphy_rx_lane_ctrl: D-PHY data-lane RX controller; LP SoT detection, settle/sync timing, HSRX enable (hs link), status/error pulses and ByteCount
module dphy_rx_lane_ctrl
  import dphy_rx_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC   = 8,
  parameter int SYNC_TIMEOUT = 32,
  parameter int LP_FILTER    = 2
) (
  input  logic                RxByteClkHS,
  input  logic                RxRst_n,
  input  logic                Enable,
  input  logic                LP_Dp,
  input  logic                LP_Dn,
  dphy_rx_lane_ctrl_if.master hs,
  output logic [2:0]          CtrlState,
  output logic                RxStopState,
  output logic                RxHsBurstDone,
  output logic                ErrSotSyncHS,
  output logic                ErrSeq,
  output logic [15:0]         ByteCount
);
  localparam int CW = $clog2(max_int(SETTLE_CYC, SYNC_TIMEOUT)) + 1;
  logic [1:0] lp;
  rx_ctrl_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] bc_q, bc_d;
  logic done_d, sot_d, seq_d;
  logic en_q, term_q, stop_q, done_q, sot_q, seq_q;
  dphy_lp_sync_filter #(.LP_FILTER(LP_FILTER)) u_lp (
    .clk_i   (RxByteClkHS),
    .rst_ni  (RxRst_n),
    .lp_dp_i (LP_Dp),
    .lp_dn_i (LP_Dn),
    .lp      (lp)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == HS_SETTLE || state_q == HS_SYNC) ? cnt_q + CW'(1) : '0;
    bc_d    = bc_q;
    done_d  = 1'b0;
    sot_d   = 1'b0;
    seq_d   = 1'b0;
    if (!Enable) state_d = DISABLED;
    else begin
      case (state_q)
        DISABLED:  if (lp == LP11) state_d = STOP;
        STOP: begin
          if (lp == LP01) state_d = HS_RQST;
          else if (lp == LP00) begin
            seq_d   = 1'b1;
            state_d = WAIT_STOP;
          end
        end
        HS_RQST: begin
          if (lp == LP00) begin
            state_d = HS_SETTLE;
            bc_d    = '0;
          end else if (lp == LP11) state_d = STOP;
          else if (lp == LP10) begin
            seq_d   = 1'b1;
            state_d = WAIT_STOP;
          end
        end
        HS_SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            state_d = HS_SYNC;
            cnt_d   = '0;
          end
        end
        HS_SYNC: begin
          if (hs.RxSyncHS) state_d = HS_DATA;
          else if (cnt_q == CW'(SYNC_TIMEOUT - 1)) begin
            sot_d   = 1'b1;
            state_d = WAIT_STOP;
          end
        end
        HS_DATA: begin
          if (hs.RxValidHS && bc_q != 16'hFFFF) bc_d = bc_q + 16'd1;
          if (lp == LP11) begin
            done_d  = 1'b1;
            state_d = STOP;
          end
        end
        WAIT_STOP: if (lp == LP11) state_d = STOP;
        default:   state_d = DISABLED;
      endcase
    end
  end
  always_ff @(posedge RxByteClkHS or negedge RxRst_n) begin
    if (!RxRst_n) begin
      state_q <= DISABLED;
      cnt_q   <= '0;
      bc_q    <= '0;
      en_q    <= 1'b0;
      term_q  <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      sot_q   <= 1'b0;
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bc_q    <= bc_d;
      en_q    <= state_d inside {HS_SYNC, HS_DATA};
      term_q  <= state_d inside {HS_SETTLE, HS_SYNC, HS_DATA};
      stop_q  <= state_d == STOP;
      done_q  <= done_d;
      sot_q   <= sot_d;
      seq_q   <= seq_d;
    end
  end
  assign CtrlState     = state_q;
  assign RxStopState   = stop_q;
  assign RxHsBurstDone = done_q;
  assign ErrSotSyncHS  = sot_q;
  assign ErrSeq        = seq_q;
  assign ByteCount     = bc_q;
  assign hs.HSRX_EN    = en_q;
  assign hs.HS_TermEn  = term_q;
endmodule

// File: doc/dphy_rx_lane_ctrl.md
# dphy_rx_lane_ctrl

Per-lane receive controller for the D-PHY data lane. It watches the low-power (LP) line states and detects the LP-11 → LP-01 → LP-00 start-of-transmission sequence. It times T_HS-SETTLE, then enables HS termination and the `DPHY_HSRX` deserializer (`HSRX_EN`). It supervises sync detection and closes the burst on the return to LP-11. It sits beside `DPHY_HSRX` in the lane receiver, consuming that block's status outputs and driving its enable.

## Interface

**Parameters**

- `SETTLE_CYC`, default 8: byte-clock cycles spent in HS_SETTLE before `HSRX_EN` asserts; legal range ≥ 1.
- `SYNC_TIMEOUT`, default 32: cycles allowed in HS_SYNC for `RxSyncHS`; legal range ≥ 1.
- `LP_FILTER`, default 2: consecutive identical synchronized LP samples required to accept a new LP state; legal range ≥ 1.

**Ports**

- `RxByteClkHS` in 1: the only clock.
- `RxRst_n` in 1: reset; asynchronous, active-low.
- `Enable` in 1: lane enable.
- `LP_Dp` in 1: asynchronous LP receiver output, Dp.
- `LP_Dn` in 1: asynchronous LP receiver output, Dn.
- `RxActiveHS` in 1: from `DPHY_HSRX`; status only, not used for sequencing.
- `RxSyncHS` in 1: sync-byte detected pulse from `DPHY_HSRX`.
- `RxValidHS` in 1: byte-valid from `DPHY_HSRX`.
- `HSRX_EN` out 1: deserializer enable.
- `HS_TermEn` out 1: HS termination enable.
- `CtrlState` out 3: current FSM state encoding.
- `RxStopState` out 1: high while in STOP.
- `RxHsBurstDone` out 1: one-cycle pulse at end of a good burst.
- `ErrSotSyncHS` out 1: one-cycle pulse on sync timeout.
- `ErrSeq` out 1: one-cycle pulse on an illegal LP sequence.
- `ByteCount` out 16: valid bytes in the current or last burst; saturates at 16'hFFFF.

## Operation

**LP sampling**
- `{LP_Dp,LP_Dn}` passes through a 2-flop synchronizer.
- The synchronized value is accepted as the filtered LP state (`lp`) once it has been stable for `LP_FILTER` consecutive cycles.
- `lp` resets to LP-00, so a lane must see a genuine LP-11 before leaving DISABLED.

**States** (`CtrlState` encoding)
- DISABLED = 0, STOP = 1, HS_RQST = 2, HS_SETTLE = 3, HS_SYNC = 4, HS_DATA = 5, WAIT_STOP = 6.

**Transitions** (checked in priority order)
- `Enable` = 0 in any state → DISABLED next cycle; all outputs go to reset values except `ByteCount`, which holds.
- DISABLED: `lp` = 11 → STOP.
- STOP:
  - `lp` = 01 → HS_RQST.
  - `lp` = 00 → `ErrSeq` pulse, → WAIT_STOP.
  - `lp` = 10 → stay in STOP; escape mode is handled outside this block.
- HS_RQST:
  - `lp` = 00 → HS_SETTLE; settle counter cleared, `ByteCount` cleared.
  - `lp` = 11 → STOP, no error.
  - `lp` = 10 → `ErrSeq` pulse, → WAIT_STOP.
- HS_SETTLE: `HS_TermEn` = 1; `lp` is ignored. After `SETTLE_CYC` cycles → HS_SYNC.
- HS_SYNC: `HS_TermEn` = 1, `HSRX_EN` = 1.
  - `RxSyncHS` → HS_DATA.
  - `SYNC_TIMEOUT` cycles elapse without sync → `ErrSotSyncHS` pulse, → WAIT_STOP.
- HS_DATA: `HS_TermEn` = 1, `HSRX_EN` = 1.
  - Each `RxValidHS` increments `ByteCount` (saturating).
  - `lp` = 11 → `RxHsBurstDone` pulse, → STOP.
- WAIT_STOP: `HSRX_EN` and `HS_TermEn` both 0. `lp` = 11 → STOP.
- Unused encoding 7 → DISABLED.

**Reset values**
- `CtrlState` = 0 (DISABLED).
- All other outputs 0.

## Timing

- All outputs are registered and change only on the rising edge of `RxByteClkHS`.
- LP input to `lp` latency: 2 + `LP_FILTER` cycles.
- If HS_SETTLE is entered at edge N:
  - `HS_TermEn` = 1 from edge N.
  - `CtrlState` = HS_SYNC and `HSRX_EN` = 1 from edge N+`SETTLE_CYC`.
- Sync timeout: if HS_SYNC is entered at edge M and `RxSyncHS` stays low, `ErrSotSyncHS` = 1 and `HSRX_EN` = 0 at edge M+`SYNC_TIMEOUT`.
- `RxSyncHS` on the final timeout cycle: sync wins, no error.
- End of burst: `HSRX_EN`, `HS_TermEn` and `RxHsBurstDone` update on the same edge that enters STOP.
- `RxValidHS` on the same cycle that `lp` = 11 is accepted: the byte is counted.
- `RxRst_n` asserted mid-burst: outputs clear immediately (asynchronously), with no burst-done pulse.

## Structure

- Package `dphy_rx_ctrl_pkg`:
  - state enum `rx_ctrl_state_t` (3 bits);
  - LP code constants `LP00`, `LP01`, `LP10`, `LP11`.
- Sub-module `dphy_lp_sync_filter`: synchronizer plus `LP_FILTER` glitch filter, with output `lp[1:0]`.
- Top module holds the FSM, the settle/timeout counter (shared, width `$clog2(max(SETTLE_CYC,SYNC_TIMEOUT))+1`) and `ByteCount`.

## Test plan

All scenarios use default parameters.

- **Nominal burst.** LP 11→01→00, `RxSyncHS` 3 cycles after HS_SYNC entry, 5 `RxValidHS`, LP → 11.
  - Expected: `HSRX_EN` high exactly 8 cycles after HS_SETTLE entry, `ByteCount` = 5, one `RxHsBurstDone` pulse, `CtrlState` returns to 1.
- **Sync timeout.** No `RxSyncHS`.
  - Expected: `ErrSotSyncHS` pulses 32 cycles after HS_SYNC entry, `HSRX_EN` drops, state = 6 until LP-11, then state = 1.
- **Illegal sequence.** LP 11→00, then separately 11→01→10.
  - Expected: `ErrSeq` pulses each time, state = 6, `HSRX_EN` never asserts.
- **Glitch rejection.** One-cycle LP-01 glitch while in STOP.
  - Expected: state stays 1, no outputs change.
- **Disable and reset mid-burst.**
  - `Enable` = 0 in HS_DATA → next cycle state = 0, `HSRX_EN` = 0, `ByteCount` holds.
  - `RxRst_n` = 0 in HS_DATA → all outputs 0 asynchronously.
- **Sync on timeout cycle and saturation.**
  - `RxSyncHS` on cycle 32 → HS_DATA with no error.
  - 65537 valid bytes → `ByteCount` = 16'hFFFF.
